// File: rtl/vector_writeback.sv
// vector_writeback: buffers 1024-bit vector ALU results in a small FIFO and
// serialises them into 512-bit register-file write beats (lo, then hi for
// wide results) over a valid/ready handshake.
module vector_writeback #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wide,
  input  logic [ADDR_W-1:0] in_addr_lo,
  input  logic [ADDR_W-1:0] in_addr_hi,
  input  logic [DATA_W-1:0] in_lo,
  input  logic [DATA_W-1:0] in_hi,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic [CNT_W-1:0]  beat_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH) + 1;

  localparam logic [0:0] PH_LO = 1'b0;
  localparam logic [0:0] PH_HI = 1'b1;

  // Entry storage; contents are only observed while the entry is occupied,
  // so the data arrays need no reset.
  logic              wide_mem    [DEPTH];
  logic [ADDR_W-1:0] addr_lo_mem [DEPTH];
  logic [ADDR_W-1:0] addr_hi_mem [DEPTH];
  logic [DATA_W-1:0] lo_mem      [DEPTH];
  logic [DATA_W-1:0] hi_mem      [DEPTH];

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [OCC_W-1:0] occ_r;
  logic [0:0]       phase_r;
  logic [CNT_W-1:0] beat_count_r;

  logic empty_s;
  logic full_s;
  logic push_s;
  logic accept_s;
  logic pop_s;
  logic head_wide_s;

  // Handshake decode; readiness depends on registered occupancy only so a
  // same-cycle pop never lets a push into a full FIFO.
  always_comb begin
    empty_s     = (occ_r == {OCC_W{1'b0}});
    full_s      = (occ_r == OCC_W'(DEPTH));
    head_wide_s = wide_mem[rd_ptr_r];
    push_s      = in_valid & ~full_s;
    accept_s    = ~empty_s & wb_ready;
    if (phase_r == PH_HI) begin
      pop_s = accept_s;
    end else begin
      pop_s = accept_s & ~head_wide_s;
    end
  end

  // Write the pushed result into the tail slot.
  always_ff @(posedge clk) begin
    if (push_s) begin
      wide_mem[wr_ptr_r]    <= in_wide;
      addr_lo_mem[wr_ptr_r] <= in_addr_lo;
      addr_hi_mem[wr_ptr_r] <= in_addr_hi;
      lo_mem[wr_ptr_r]      <= in_lo;
      hi_mem[wr_ptr_r]      <= in_hi;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= {OCC_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + {{(OCC_W-1){1'b0}}, 1'b1};
        2'b01:   occ_r <= occ_r - {{(OCC_W-1){1'b0}}, 1'b1};
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Beat phase of the head entry: a wide head takes a lo beat then a hi beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_r <= PH_LO;
    end else if (accept_s) begin
      case (phase_r)
        PH_LO:   phase_r <= head_wide_s ? PH_HI : PH_LO;
        PH_HI:   phase_r <= PH_LO;
        default: phase_r <= PH_LO;
      endcase
    end else begin
      phase_r <= phase_r;
    end
  end

  // Saturating count of beats accepted by the register file.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_count_r <= {CNT_W{1'b0}};
    end else if (accept_s && (beat_count_r != {CNT_W{1'b1}})) begin
      beat_count_r <= beat_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      beat_count_r <= beat_count_r;
    end
  end

  // Output beat mux from registered head state; forced to zero when idle, and
  // naturally stable under stall because head and phase only move on accept.
  always_comb begin
    wb_addr = {ADDR_W{1'b0}};
    wb_data = {DATA_W{1'b0}};
    if (empty_s) begin
      wb_addr = {ADDR_W{1'b0}};
      wb_data = {DATA_W{1'b0}};
    end else if (phase_r == PH_HI) begin
      wb_addr = addr_hi_mem[rd_ptr_r];
      wb_data = hi_mem[rd_ptr_r];
    end else begin
      wb_addr = addr_lo_mem[rd_ptr_r];
      wb_data = lo_mem[rd_ptr_r];
    end
  end

  assign in_ready   = ~full_s;
  assign wb_valid   = ~empty_s;
  assign busy       = ~empty_s;
  assign beat_count = beat_count_r;

endmodule
